// File: rtl/remote_throttle_sequencer.sv
// remote_throttle_sequencer
//   Owns the 8-bit throttle channel to the remote transmitter.
//   arm_req (in IDLE) runs the arming pattern: 0 for LOW_CYCLES, 255 for
//   HIGH_CYCLES, 0 for SETTLE_CYCLES. It then enters ACTIVE, where cmd_value
//   targets are followed with a per-cycle slew limit of STEP.
//   A command watchdog timeout drops to FAILSAFE, which ramps the throttle down
//   to 0 and then returns to IDLE. disarm_req returns to IDLE at once.
//
// Ports
//   clock, reset   : rising-edge clock; asynchronous active-high reset
//   arm_req        : start arming (IDLE only)
//   disarm_req     : immediate return to IDLE from any non-IDLE state
//   cmd_valid      : cmd_value carries a new throttle target
//   cmd_value[7:0] : throttle target
//   throttle_out   : registered throttle channel
//   armed          : high in ACTIVE
//   busy           : high in ARM_LOW / ARM_HIGH / ARM_SETTLE / FAILSAFE
module remote_throttle_sequencer #(
  parameter int LOW_CYCLES     = 16,
  parameter int HIGH_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int STEP           = 4,
  parameter int CW             = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       arm_req,
  input  logic       disarm_req,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_value,
  output logic [7:0] throttle_out,
  output logic       armed,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ARM_LOW, ARM_HIGH, ARM_SETTLE, ACTIVE, FAILSAFE
  } state_t;

  localparam logic [CW-1:0] LOW_LAST    = CW'(LOW_CYCLES - 1);
  localparam logic [CW-1:0] HIGH_LAST   = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]    STEP9       = 9'(STEP);

  state_t        state_q;
  logic [CW-1:0] cnt_q;     // hold counter in ARM_*, watchdog in ACTIVE
  logic [7:0]    target_q;
  logic [7:0]    thr_q;
  logic          armed_q;
  logic          busy_q;

  // Slew step toward target_q. The gap is computed in 9 bits so that a step
  // can never overshoot the target or wrap through 0/255.
  logic [8:0] up_gap, dn_gap;
  logic [7:0] slew;
  always_comb begin
    up_gap = {1'b0, target_q} - {1'b0, thr_q};
    dn_gap = {1'b0, thr_q} - {1'b0, target_q};
    slew   = thr_q;
    if (target_q > thr_q)
      slew = (up_gap > STEP9) ? 8'({1'b0, thr_q} + STEP9) : target_q;
    else if (thr_q > target_q)
      slew = (dn_gap > STEP9) ? 8'({1'b0, thr_q} - STEP9) : target_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      thr_q    <= '0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else if (disarm_req && state_q != IDLE) begin
      // Hard stop: the throttle is not slewed down.
      state_q  <= IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      thr_q    <= '0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          thr_q <= '0;
          if (arm_req && !disarm_req) begin
            state_q <= ARM_LOW;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ARM_LOW: begin
          if (cnt_q == LOW_LAST) begin
            state_q <= ARM_HIGH;
            cnt_q   <= '0;
            thr_q   <= 8'd255;
          end else cnt_q <= cnt_q + CW'(1);
        end
        ARM_HIGH: begin
          if (cnt_q == HIGH_LAST) begin
            state_q <= ARM_SETTLE;
            cnt_q   <= '0;
            thr_q   <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        end
        ARM_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q  <= ACTIVE;
            cnt_q    <= '0;
            target_q <= '0;
            armed_q  <= 1'b1;
            busy_q   <= 1'b0;
          end else cnt_q <= cnt_q + CW'(1);
        end
        ACTIVE: begin
          thr_q <= slew;
          // Timeout outranks a command arriving in the same cycle.
          if (cnt_q == TO_LAST) begin
            state_q  <= FAILSAFE;
            cnt_q    <= '0;
            target_q <= '0;
            armed_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else if (cmd_valid) begin
            target_q <= cmd_value;
            cnt_q    <= '0;
          end else cnt_q <= cnt_q + CW'(1);
        end
        FAILSAFE: begin
          // target_q is 0 here, so slew is a clamped ramp-down.
          if (thr_q == 8'd0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else thr_q <= slew;
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          target_q <= '0;
          thr_q    <= '0;
          armed_q  <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign throttle_out = thr_q;
  assign armed        = armed_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_remote_throttle_sequencer.sv
module tb_remote_throttle_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       arm_req = 1'b0;
  logic       disarm_req = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_value = 8'd0;
  logic [7:0] throttle_out;
  logic       armed;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;

  remote_throttle_sequencer dut (
    .clock        (clock),
    .reset        (reset),
    .arm_req      (arm_req),
    .disarm_req   (disarm_req),
    .cmd_valid    (cmd_valid),
    .cmd_value    (cmd_value),
    .throttle_out (throttle_out),
    .armed        (armed),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Pulse arm_req and wait out the 48-cycle arming pattern (ends in ACTIVE).
  task automatic do_arm();
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    repeat (48) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL reset_state: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
    reset = 1'b0;
    tick();
    // cmd_valid in IDLE must be ignored
    cmd_valid = 1'b1; cmd_value = 8'd77;
    tick(); tick();
    cmd_valid = 1'b0;
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL idle_cmd_ignored: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
  endtask

  task automatic test_arming();
    logic [9:0] exp;
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    for (int i = 0; i < 48; i++) begin
      exp = {((i >= 16 && i < 32) ? 8'd255 : 8'd0), 1'b0, 1'b1};
      n_total++;
      if ({throttle_out, armed, busy} !== exp) $display("FAIL arm_seq[%0d]: got thr=%0d armed=%0d busy=%0d expected thr=%0d armed=0 busy=1", i, throttle_out, armed, busy, exp[9:2]);
      else n_pass++;
      tick();
    end
    n_total++;
    if ({throttle_out, armed, busy} !== {8'd0, 1'b1, 1'b0}) $display("FAIL arm_active: got thr=%0d armed=%0d busy=%0d expected thr=0 armed=1 busy=0", throttle_out, armed, busy);
    else n_pass++;
  endtask

  task automatic test_slew();
    logic [7:0] up_seq [4] = '{8'd0, 8'd4, 8'd8, 8'd10};
    logic [7:0] dn_seq [4] = '{8'd10, 8'd6, 8'd2, 8'd0};
    cmd_valid = 1'b1; cmd_value = 8'd10;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (throttle_out !== up_seq[i]) $display("FAIL slew_up[%0d]: got %0d expected %0d", i, throttle_out, up_seq[i]);
      else n_pass++;
      tick();
    end
    n_total++;
    if (throttle_out !== 8'd10) $display("FAIL slew_hold: got %0d expected 10", throttle_out);
    else n_pass++;
    cmd_valid = 1'b1; cmd_value = 8'd0;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (throttle_out !== dn_seq[i]) $display("FAIL slew_dn[%0d]: got %0d expected %0d", i, throttle_out, dn_seq[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_value = 8'd200;
    tick();
    cmd_valid = 1'b0;
    repeat (999) tick();
    n_total++;
    if ({throttle_out, armed, busy} !== {8'd200, 1'b1, 1'b0}) $display("FAIL pre_timeout: got thr=%0d armed=%0d busy=%0d expected thr=200 armed=1 busy=0", throttle_out, armed, busy);
    else n_pass++;
    tick();
    n_total++;
    if ({throttle_out, armed, busy} !== {8'd200, 1'b0, 1'b1}) $display("FAIL timeout_entry: got thr=%0d armed=%0d busy=%0d expected thr=200 armed=0 busy=1", throttle_out, armed, busy);
    else n_pass++;
    // a command arriving in FAILSAFE must be ignored
    cmd_valid = 1'b1; cmd_value = 8'd250;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (i == 2) cmd_valid = 1'b0;
      n_total++;
      if ({throttle_out, busy} !== {8'(200 - 4 * i), 1'b1}) $display("FAIL failsafe_ramp[%0d]: got thr=%0d busy=%0d expected thr=%0d busy=1", i, throttle_out, busy, 200 - 4 * i);
      else n_pass++;
    end
    tick();
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL failsafe_idle: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
  endtask

  task automatic test_disarm();
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    repeat (20) tick();
    n_total++;
    if ({throttle_out, busy} !== {8'd255, 1'b1}) $display("FAIL disarm_pre: got thr=%0d busy=%0d expected thr=255 busy=1", throttle_out, busy);
    else n_pass++;
    disarm_req = 1'b1;
    tick();
    disarm_req = 1'b0;
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL disarm_now: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL disarm_stay_idle: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
    // disarm together with arm in IDLE: disarm wins
    arm_req = 1'b1; disarm_req = 1'b1;
    tick();
    arm_req = 1'b0; disarm_req = 1'b0;
    tick();
    n_total++;
    if (busy !== 1'b0) $display("FAIL disarm_arm_idle: got busy=%0d expected 0", busy);
    else n_pass++;
    // rearm restarts the full sequence from ARM_LOW
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    repeat (15) tick();
    n_total++;
    if ({throttle_out, busy} !== {8'd0, 1'b1}) $display("FAIL rearm_low_end: got thr=%0d busy=%0d expected thr=0 busy=1", throttle_out, busy);
    else n_pass++;
    tick();
    n_total++;
    if (throttle_out !== 8'd255) $display("FAIL rearm_high_start: got %0d expected 255", throttle_out);
    else n_pass++;
    disarm_req = 1'b1;
    tick();
    disarm_req = 1'b0;
  endtask

  task automatic test_arm_ignore();
    logic [7:0] exp;
    arm_req = 1'b1;
    tick();
    arm_req = 1'b0;
    for (int i = 0; i < 48; i++) begin
      arm_req   = (i >= 3 && i <= 8);
      cmd_valid = (i >= 34 && i <= 40);
      cmd_value = 8'd200;
      exp = (i >= 16 && i < 32) ? 8'd255 : 8'd0;
      n_total++;
      if ({throttle_out, busy} !== {exp, 1'b1}) $display("FAIL arm_ignore[%0d]: got thr=%0d busy=%0d expected thr=%0d busy=1", i, throttle_out, busy, exp);
      else n_pass++;
      tick();
    end
    arm_req = 1'b0; cmd_valid = 1'b0;
    repeat (4) tick();
    n_total++;
    if ({throttle_out, armed} !== {8'd0, 1'b1}) $display("FAIL settle_cmd_dropped: got thr=%0d armed=%0d expected thr=0 armed=1", throttle_out, armed);
    else n_pass++;
    disarm_req = 1'b1;
    tick();
    disarm_req = 1'b0;
  endtask

  task automatic test_reset_active();
    do_arm();
    cmd_valid = 1'b1; cmd_value = 8'd120;
    tick();
    cmd_valid = 1'b0;
    repeat (30) tick();
    n_total++;
    if ({throttle_out, armed} !== {8'd120, 1'b1}) $display("FAIL pre_reset: got thr=%0d armed=%0d expected thr=120 armed=1", throttle_out, armed);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL async_reset: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
    #10 reset = 1'b0;
    repeat (5) tick();
    n_total++;
    if ({throttle_out, armed, busy} !== 10'd0) $display("FAIL post_reset_idle: got thr=%0d armed=%0d busy=%0d expected all 0", throttle_out, armed, busy);
    else n_pass++;
    do_arm();
    n_total++;
    if (armed !== 1'b1) $display("FAIL post_reset_rearm: got armed=%0d expected 1", armed);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_arming();
    test_slew();
    test_timeout();
    test_disarm();
    test_arm_ignore();
    test_reset_active();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
